// File: rtl/dmem_loader.sv
// dmem_loader: owns the single access port of the 256x8 data memory.
// In IDLE the processor's load/store signals pass straight through to memory.
// A start pulse stalls the processor and streams bytes (valid/ready) into
// consecutive addresses from base_addr, wrapping modulo 2**AW.
// Optional feature macro: DMEM_LOADER_VERIFY_EN adds a one-cycle readback
// check after every written byte and drives a sticky error flag.
module dmem_loader #(
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int LENW = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [LENW-1:0] length,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  input  logic [AW-1:0]   cpu_addr,
  input  logic            cpu_read,
  input  logic            cpu_write,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_read,
  output logic            mem_write,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic            error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Largest transfer: one full pass over the memory.
  localparam logic [LENW-1:0] MAX_LEN = LENW'(2**AW);

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic            hs;

  // A byte is taken only when the loader is ready (ready already gated by reset).
  assign hs = in_valid & in_ready;

`ifdef DMEM_LOADER_VERIFY_EN
  logic          error_q, error_d;
  logic [DW-1:0] vbyte_q, vbyte_d;

  // Sticky readback mismatch flag and the byte awaiting its readback check.
  always_comb begin
    error_d = error_q;
    vbyte_d = vbyte_q;
    if (state_q == S_LOAD && hs) vbyte_d = in_data;
    if (state_q == S_VERIFY && mem_rdata != vbyte_q) error_d = 1'b1;
  end

  // Control flag is reset; the captured data byte is not.
  always_ff @(posedge clk) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_d;
    vbyte_q <= vbyte_d;
  end

  assign error = error_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign error        = 1'b0;
`endif

  // State, write pointer and remaining-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic; start is honoured only in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (length == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (hs) begin
`ifdef DMEM_LOADER_VERIFY_EN
          state_d = S_VERIFY;
`else
          if (rem_q == LENW'(1)) state_d = S_DONE;
`endif
        end
      end
`ifdef DMEM_LOADER_VERIFY_EN
      // rem_q was already decremented by the write that preceded this check.
      S_VERIFY: state_d = (rem_q == '0) ? S_DONE : S_LOAD;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer/count updates: load on start, advance on every accepted byte.
  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (state_q == S_IDLE && start && length != '0) begin
      ptr_d = base_addr;
      rem_d = (length > MAX_LEN) ? MAX_LEN : length;
    end else if (state_q == S_LOAD && hs) begin
      ptr_d = ptr_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
  end

  // Output decode: memory port mux, handshake ready and status flags.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_read  = cpu_read;
    mem_write = cpu_write;
    mem_wdata = cpu_wdata;
    in_ready  = 1'b0;
    stall     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
      end
      S_LOAD: begin
        stall     = 1'b1;
        busy      = 1'b1;
        in_ready  = 1'b1;
        mem_addr  = ptr_q;
        mem_read  = 1'b0;
        mem_write = in_valid;
        mem_wdata = in_data;
      end
`ifdef DMEM_LOADER_VERIFY_EN
      S_VERIFY: begin
        stall     = 1'b1;
        busy      = 1'b1;
        mem_addr  = ptr_q - 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        mem_wdata = vbyte_q;
      end
`endif
      S_DONE: begin
        stall     = 1'b1;
        done      = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      default: begin
      end
    endcase
    // Reset forces the memory port and handshake quiet regardless of state.
    if (reset) begin
      in_ready  = 1'b0;
      stall     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_loader.sv
// Directed testbench for dmem_loader with a behavioural 256x8 memory.
module tb_dmem_loader;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, in_ready;
  logic [7:0] base_addr, in_data, cpu_addr, cpu_wdata, mem_addr, mem_wdata, mem_rdata;
  logic [8:0] length;
  logic       cpu_read, cpu_write, mem_read, mem_write, stall, busy, done, error;

  logic [7:0] mem [256];
  logic       corrupt_en;
  logic [7:0] corrupt_addr;
  int         wcnt = 0;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  dmem_loader #(.AW(8), .DW(8), .LENW(9)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .busy(busy), .done(done), .error(error)
  );

  assign mem_rdata = (corrupt_en && mem_addr == corrupt_addr) ? ~mem[mem_addr] : mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      wcnt <= wcnt + 1;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; length = 9'd5; in_valid = 1'b1;
    cpu_read = 1'b1; cpu_write = 1'b1;
    next(); next(); #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL rst_stall got %b want 0", stall); end
    nvec++; if (mem_write !== 1'b0) begin nerr++; $display("FAIL rst_mem_write got %b want 0", mem_write); end
    nvec++; if (mem_read !== 1'b0) begin nerr++; $display("FAIL rst_mem_read got %b want 0", mem_read); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %b want 0", done); end
    nvec++; if (error !== 1'b0) begin nerr++; $display("FAIL rst_error got %b want 0", error); end
    start = 1'b0; in_valid = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; length = 9'd0;
    reset = 1'b0;
    next(); #1;
    nvec++; if (stall !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL rst_idle stall/busy got %b%b want 00", stall, busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    int w0;
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
    w0 = wcnt;
    start = 1'b1; base_addr = 8'h10; length = 9'd4;
    next();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = bytes[i]; #1;
      nvec++; if (mem_write !== 1'b1 || mem_addr !== 8'(8'h10 + i) || in_ready !== 1'b1 || stall !== 1'b1) begin
        nerr++; $display("FAIL b2b_cyc%0d wr/addr/rdy/stall got %b/%h/%b/%b want 1/%h/1/1", i, mem_write, mem_addr, in_ready, stall, 8'(8'h10 + i));
      end
      next();
    end
    in_valid = 1'b0; #1;
    nvec++; if (done !== 1'b1 || stall !== 1'b1 || in_ready !== 1'b0) begin nerr++; $display("FAIL b2b_done done/stall/rdy got %b/%b/%b want 1/1/0", done, stall, in_ready); end
    next(); #1;
    nvec++; if (done !== 1'b0 || stall !== 1'b0) begin nerr++; $display("FAIL b2b_after done/stall got %b/%b want 0/0", done, stall); end
    nvec++; if (mem[8'h10] !== 8'hAA || mem[8'h11] !== 8'hBB || mem[8'h12] !== 8'hCC || mem[8'h13] !== 8'hDD) begin
      nerr++; $display("FAIL b2b_mem got %h %h %h %h want aa bb cc dd", mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
    end
    nvec++; if (wcnt - w0 !== 4) begin nerr++; $display("FAIL b2b_wcnt got %0d want 4", wcnt - w0); end
    nvec++; if (error !== 1'b0) begin nerr++; $display("FAIL b2b_error got %b want 0", error); end
  endtask

  task automatic test_wrap();
    start = 1'b1; base_addr = 8'hFE; length = 9'd3;
    next();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1); next();
    end
    in_valid = 1'b0; #1;
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL wrap_done got %b want 1", done); end
    nvec++; if (mem[8'hFE] !== 8'h01 || mem[8'hFF] !== 8'h02 || mem[8'h00] !== 8'h03) begin
      nerr++; $display("FAIL wrap_mem got %h %h %h want 01 02 03", mem[8'hFE], mem[8'hFF], mem[8'h00]);
    end
    next();
  endtask

  task automatic test_gaps();
    logic vpat [6];
    int w0;
    int k;
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b1; vpat[3] = 1'b0; vpat[4] = 1'b1; vpat[5] = 1'b1;
    w0 = wcnt; k = 0;
    start = 1'b1; base_addr = 8'h50; length = 9'd4;
    next();
    start = 1'b0;
    cpu_write = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h77;
    for (int i = 0; i < 6; i++) begin
      in_valid = vpat[i]; in_data = 8'(8'hE0 + k);
      // A start during LOAD must be ignored.
      start = (i == 1); base_addr = 8'h90;
      #1;
      nvec++; if (in_ready !== 1'b1 || done !== 1'b0 || mem_write !== vpat[i] || (vpat[i] && mem_addr !== 8'(8'h50 + k))) begin
        nerr++; $display("FAIL gap_cyc%0d rdy/done/wr/addr got %b/%b/%b/%h want 1/0/%b/%h", i, in_ready, done, mem_write, mem_addr, vpat[i], 8'(8'h50 + k));
      end
      if (vpat[i]) k++;
      next();
    end
    start = 1'b0; in_valid = 1'b0; #1;
    nvec++; if (done !== 1'b1 || mem_write !== 1'b0) begin nerr++; $display("FAIL gap_done done/wr got %b/%b want 1/0", done, mem_write); end
    cpu_write = 1'b0;
    next();
    nvec++; if (wcnt - w0 !== 4 || mem[8'h53] !== 8'hE3) begin nerr++; $display("FAIL gap_writes got %0d/%h want 4/e3", wcnt - w0, mem[8'h53]); end
  endtask

  task automatic test_passthrough();
    int w0;
    cpu_write = 1'b1; cpu_read = 1'b0; cpu_addr = 8'h20; cpu_wdata = 8'h55; #1;
    nvec++; if (mem_write !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h55 || stall !== 1'b0) begin
      nerr++; $display("FAIL pass_wr wr/addr/data/stall got %b/%h/%h/%b want 1/20/55/0", mem_write, mem_addr, mem_wdata, stall);
    end
    next();
    cpu_write = 1'b0; cpu_read = 1'b1; #1;
    nvec++; if (mem[8'h20] !== 8'h55 || mem_read !== 1'b1) begin nerr++; $display("FAIL pass_rd mem/rd got %h/%b want 55/1", mem[8'h20], mem_read); end
    cpu_read = 1'b0;
    w0 = wcnt;
    start = 1'b1; length = 9'd0; base_addr = 8'h60;
    next();
    start = 1'b0; #1;
    nvec++; if (done !== 1'b1 || mem_write !== 1'b0) begin nerr++; $display("FAIL len0_done done/wr got %b/%b want 1/0", done, mem_write); end
    next();
    nvec++; if (done !== 1'b0 || wcnt - w0 !== 0) begin nerr++; $display("FAIL len0_after done/writes got %b/%0d want 0/0", done, wcnt - w0); end
  endtask

  task automatic test_reset_midload();
    int w0;
    w0 = wcnt;
    start = 1'b1; base_addr = 8'h40; length = 9'd5;
    next();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; next();
    in_data = 8'h22; next();
    in_data = 8'h33; reset = 1'b1; #1;
    nvec++; if (mem_write !== 1'b0 || in_ready !== 1'b0 || stall !== 1'b0) begin
      nerr++; $display("FAIL mid_rst wr/rdy/stall got %b/%b/%b want 0/0/0", mem_write, in_ready, stall);
    end
    next();
    reset = 1'b0; #1;
    nvec++; if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL mid_idle stall/busy/done/rdy got %b/%b/%b/%b want 0/0/0/0", stall, busy, done, in_ready);
    end
    in_valid = 1'b0;
    next();
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL mid_nodone got %b want 0", done); end
    nvec++; if (wcnt - w0 !== 2 || mem[8'h40] !== 8'h11 || mem[8'h41] !== 8'h22) begin
      nerr++; $display("FAIL mid_mem writes/m40/m41 got %0d/%h/%h want 2/11/22", wcnt - w0, mem[8'h40], mem[8'h41]);
    end
  endtask

  task automatic test_clamp();
    int w0;
    int n;
    w0 = wcnt; n = 0;
    start = 1'b1; base_addr = 8'h00; length = 9'd300;
    next();
    start = 1'b0; in_valid = 1'b1;
    while (n < 300) begin
      in_data = 8'(n); #1;
      if (done) break;
      next();
      n++;
    end
    in_valid = 1'b0;
    nvec++; if (n !== 256) begin nerr++; $display("FAIL clamp_cycles got %0d want 256", n); end
    nvec++; if (wcnt - w0 !== 256 || mem[8'h10] !== 8'h10 || mem[8'hFF] !== 8'hFF) begin
      nerr++; $display("FAIL clamp_mem writes/m10/mff got %0d/%h/%h want 256/10/ff", wcnt - w0, mem[8'h10], mem[8'hFF]);
    end
    next();
  endtask

`ifdef DMEM_LOADER_VERIFY_EN
  task automatic test_verify();
    logic [7:0] bytes [3];
    bytes[0] = 8'h5A; bytes[1] = 8'hC3; bytes[2] = 8'h0F;
    corrupt_en = 1'b1; corrupt_addr = 8'h81;
    start = 1'b1; base_addr = 8'h80; length = 9'd3;
    next();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = bytes[k / 2]; #1;
      if (k % 2 == 0) begin
        nvec++; if (in_ready !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 8'(8'h80 + k / 2)) begin
          nerr++; $display("FAIL ver_ld%0d rdy/wr/addr got %b/%b/%h", k, in_ready, mem_write, mem_addr);
        end
      end else begin
        nvec++; if (in_ready !== 1'b0 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 8'(8'h80 + k / 2)) begin
          nerr++; $display("FAIL ver_chk%0d rdy/rd/wr/addr got %b/%b/%b/%h", k, in_ready, mem_read, mem_write, mem_addr);
        end
      end
      nvec++; if (error !== (k >= 4)) begin nerr++; $display("FAIL ver_err%0d got %b want %b", k, error, (k >= 4)); end
      next();
    end
    in_valid = 1'b0; corrupt_en = 1'b0; #1;
    nvec++; if (done !== 1'b1 || error !== 1'b1) begin nerr++; $display("FAIL ver_done done/err got %b/%b want 1/1", done, error); end
    next();
    nvec++; if (error !== 1'b1 || mem[8'h81] !== 8'hC3) begin nerr++; $display("FAIL ver_sticky err/m81 got %b/%h want 1/c3", error, mem[8'h81]); end
    reset = 1'b1; next(); reset = 1'b0; #1;
    nvec++; if (error !== 1'b0) begin nerr++; $display("FAIL ver_clr got %b want 0", error); end
    start = 1'b1; base_addr = 8'h90; length = 9'd2;
    next();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h66;
    for (int k = 0; k < 4; k++) next();
    in_valid = 1'b0; #1;
    nvec++; if (done !== 1'b1 || error !== 1'b0) begin nerr++; $display("FAIL ver_clean done/err got %b/%b want 1/0", done, error); end
    next();
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0; in_data = '0;
    cpu_addr = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = '0;
    corrupt_en = 1'b0; corrupt_addr = '0;
    next();
    test_reset();
`ifdef DMEM_LOADER_VERIFY_EN
    test_passthrough();
    test_verify();
`else
    test_back_to_back();
    test_wrap();
    test_gaps();
    test_passthrough();
    test_reset_midload();
    test_clamp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
